mem_map: RTL and testbench



---
 rtl/mem_map.sv | 168 ++++++++++++++++
 tb/tb_mem_map.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map.sv
`default_nettype none
// ============================================================================
// Module      : mem_map
// Description : Address decoder / access arbiter for NUM_REGIONS targets with
//               busy stalling, timeout abort and 1-cycle read response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_map #(
    parameter int                          NUM_REGIONS  = 3,
    parameter int                          ADDR_W       = 16,
    parameter int                          DATA_W       = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h6000, 16'h4000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFFFF, 16'hE000, 16'hC000},
    parameter logic [DATA_W-1:0]           DEFAULT_DATA = '0,
    parameter int                          MAX_WAIT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic                          load,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             in,
    output logic                          ready,
    output logic [DATA_W-1:0]             out,
    output logic                          out_valid,
    output logic                          err,
    output logic [NUM_REGIONS-1:0]        tgt_load,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic [DATA_W-1:0]             tgt_din,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_dout,
    input  logic [NUM_REGIONS-1:0]        tgt_busy
);

    localparam int          c_sel_w     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    // Stall cycles (ready low) are counted from the presentation cycle, so the
    // abort lands exactly MAX_WAIT cycles after the request first appeared.
    localparam logic [15:0] c_wait_last = 16'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_hit;
    logic [c_sel_w-1:0]   w_sel;
    logic                 w_latch;
    logic                 w_wait_inc;
    logic [c_sel_w-1:0]   w_resp_sel;
    logic                 w_resp_dflt;

    logic [ADDR_W-1:0]    r_hold_addr;
    logic [DATA_W-1:0]    r_hold_din;
    logic                 r_hold_load;
    logic [c_sel_w-1:0]   r_hold_sel;
    logic [15:0]          r_wait_cnt;
    logic [c_sel_w-1:0]   r_resp_sel;
    logic                 r_resp_dflt;
    logic [DATA_W-1:0]    r_out_q;

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((address & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_sel = c_sel_w'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        err          = 1'b0;
        tgt_load     = '0;
        w_latch      = 1'b0;
        w_wait_inc   = 1'b0;
        w_resp_sel   = r_resp_sel;
        w_resp_dflt  = r_resp_dflt;
        tgt_addr     = (r_state == WAIT) ? r_hold_addr : address;
        tgt_din      = (r_state == WAIT) ? r_hold_din  : in;
        if (rst_n) begin
            case (r_state)
                WAIT: begin
                    if (!req) begin
                        w_next_state = IDLE;
                    end else if (!tgt_busy[r_hold_sel]) begin
                        ready                = 1'b1;
                        tgt_load[r_hold_sel] = r_hold_load;
                        w_next_state         = r_hold_load ? IDLE : RESP;
                        w_resp_sel           = r_hold_sel;
                        w_resp_dflt          = 1'b0;
                    end else if (r_wait_cnt == c_wait_last) begin
                        ready        = 1'b1;
                        err          = 1'b1;
                        w_next_state = r_hold_load ? IDLE : RESP;
                        w_resp_dflt  = 1'b1;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    if (req) begin
                        if (!w_hit) begin
                            ready        = 1'b1;
                            err          = 1'b1;
                            w_next_state = load ? IDLE : RESP;
                            w_resp_dflt  = 1'b1;
                        end else if (!tgt_busy[w_sel]) begin
                            ready           = 1'b1;
                            tgt_load[w_sel] = load;
                            w_next_state    = load ? IDLE : RESP;
                            w_resp_sel      = w_sel;
                            w_resp_dflt     = 1'b0;
                        end else begin
                            w_latch      = 1'b1;
                            w_next_state = WAIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold_addr <= '0;
            r_hold_din  <= '0;
            r_hold_load <= 1'b0;
            r_hold_sel  <= '0;
            r_wait_cnt  <= '0;
            r_resp_sel  <= '0;
            r_resp_dflt <= 1'b0;
            r_out_q     <= DEFAULT_DATA;
        end else begin
            r_state     <= w_next_state;
            r_resp_sel  <= w_resp_sel;
            r_resp_dflt <= w_resp_dflt;
            if (w_latch) begin
                r_hold_addr <= address;
                r_hold_din  <= in;
                r_hold_load <= load;
                r_hold_sel  <= w_sel;
                r_wait_cnt  <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (out_valid) begin
                r_out_q <= out;
            end
        end
    end

    // Target read data is only valid in the response cycle, so the result is
    // muxed live there and captured for the hold-last-value behaviour.
    assign out_valid = (r_state == RESP);
    assign out       = !out_valid  ? r_out_q :
                       r_resp_dflt ? DEFAULT_DATA :
                                     tgt_dout[r_resp_sel*DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_mem_map.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_map
// Description : Self-checking bench for mem_map: vector table, directed
//               reset/priority sequences and a randomized transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_map;

    localparam int          c_maxw = 4;
    localparam logic [15:0] c_def  = 16'hDEAD;
    localparam logic [15:0] c_defb = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, load, req_b;
    logic [15:0] address, in;
    logic        ready, out_valid, err;
    logic [15:0] out, tgt_addr, tgt_din;
    logic [2:0]  tgt_load, tgt_busy;
    logic [47:0] tgt_dout;
    logic        ready_b, out_valid_b, err_b;
    logic [15:0] out_b, tgt_addr_b, tgt_din_b;
    logic [1:0]  tgt_load_b;
    logic [31:0] tgt_dout_b = 32'h1111_2222;
    logic [1:0]  tgt_busy_b = 2'b00;

    always #5 clk = ~clk;

    mem_map #(.MAX_WAIT(c_maxw), .DEFAULT_DATA(c_def)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .load(load), .address(address), .in(in),
        .ready(ready), .out(out), .out_valid(out_valid), .err(err),
        .tgt_load(tgt_load), .tgt_addr(tgt_addr), .tgt_din(tgt_din),
        .tgt_dout(tgt_dout), .tgt_busy(tgt_busy));

    // Overlapping custom map: region 1 lies inside region 0, nothing above 16'h3FFF.
    mem_map #(.NUM_REGIONS(2), .REGION_BASE({16'h2000, 16'h0000}),
              .REGION_MASK({16'hF000, 16'hC000}), .DEFAULT_DATA(c_defb)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .load(load), .address(address), .in(in),
        .ready(ready_b), .out(out_b), .out_valid(out_valid_b), .err(err_b),
        .tgt_load(tgt_load_b), .tgt_addr(tgt_addr_b), .tgt_din(tgt_din_b),
        .tgt_dout(tgt_dout_b), .tgt_busy(tgt_busy_b));

    int          n_pass = 0, n_total = 0;
    logic        pend = 1'b0, pend_dflt = 1'b0;
    int          pend_reg = 0;
    logic [15:0] last_out = c_def;
    logic        rnd_dout = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic        ld;
        logic [15:0] data;
        int          nbusy;
        int          e_stall;
        logic        e_err;
        logic [2:0]  e_tl;
        int          e_reg;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Checks the current cycle, then schedules the next cycle's read response.
    task automatic step(input logic e_ready, input logic e_err, input logic [2:0] e_tl,
                        input logic n_pend, input logic n_dflt, input int n_reg);
        logic [15:0] exp_out;
        chk("ready", ready, e_ready);
        chk("err", err, e_err);
        chk("tgt_load", tgt_load, e_tl);
        chk("out_valid", out_valid, pend);
        if (pend) exp_out = pend_dflt ? c_def : tgt_dout[pend_reg*16 +: 16];
        else      exp_out = last_out;
        chk("out", out, exp_out);
        if (pend) last_out = exp_out;
        pend      = n_pend;
        pend_dflt = n_dflt;
        pend_reg  = n_reg;
        @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v);
        req = 1'b1; load = v.ld; address = v.addr; in = v.data;
        for (int k = 0; k <= v.e_stall; k++) begin
            tgt_busy = 3'($urandom);
            if (v.e_reg >= 0) tgt_busy[v.e_reg] = (k < v.nbusy);
            if (rnd_dout) tgt_dout = {16'($urandom), 16'($urandom), 16'($urandom)};
            #2;
            chk("tgt_addr", tgt_addr, v.addr);
            if (k < v.e_stall) step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0);
            else begin
                if (v.ld && !v.e_err) chk("tgt_din", tgt_din, v.data);
                step(1'b1, v.e_err, v.e_tl, !v.ld, v.e_err, (v.e_reg < 0) ? 0 : v.e_reg);
            end
        end
    endtask

    task automatic idle_cycle();
        req = 1'b0; load = 1'($urandom); address = 16'($urandom);
        tgt_busy = 3'($urandom);
        if (rnd_dout) tgt_dout = {16'($urandom), 16'($urandom), 16'($urandom)};
        #2;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    endtask

    // Reference: the decoded region is the first base/mask rule that matches.
    function automatic int region_of(input logic [15:0] a);
        logic [15:0] bases [3];
        logic [15:0] masks [3];
        bases = '{16'h0000, 16'h4000, 16'h6000};
        masks = '{16'hC000, 16'hE000, 16'hFFFF};
        for (int i = 0; i < 3; i++)
            if ((a & masks[i]) == bases[i]) return i;
        return -1;
    endfunction

    function automatic vec_t model_txn(input logic [15:0] a, input logic ld,
                                       input logic [15:0] d, input int nb);
        vec_t v;
        v.addr = a; v.ld = ld; v.data = d; v.nbusy = nb;
        v.e_reg = region_of(a);
        if (v.e_reg < 0) begin
            v.e_stall = 0; v.e_err = 1'b1; v.e_tl = 3'b000;
        end else begin
            v.e_err   = (nb > c_maxw);
            v.e_stall = v.e_err ? c_maxw : nb;
            v.e_tl    = (!v.e_err && ld) ? 3'(1 << v.e_reg) : 3'b000;
        end
        return v;
    endfunction

    initial begin
        tbl[0]  = '{16'h0005, 1'b1, 16'h1234, 0, 0, 1'b0, 3'b001, 0};
        tbl[1]  = '{16'h4000, 1'b0, 16'h0000, 0, 0, 1'b0, 3'b000, 1};
        tbl[2]  = '{16'h0001, 1'b0, 16'h0000, 0, 0, 1'b0, 3'b000, 0};
        tbl[3]  = '{16'h4010, 1'b1, 16'h0BEE, 3, 3, 1'b0, 3'b010, 1};
        tbl[4]  = '{16'h4ABC, 1'b0, 16'h0000, 9, 4, 1'b1, 3'b000, 1};
        tbl[5]  = '{16'h6000, 1'b0, 16'h0000, 0, 0, 1'b0, 3'b000, 2};
        tbl[6]  = '{16'h6001, 1'b0, 16'h0000, 0, 0, 1'b1, 3'b000, -1};
        tbl[7]  = '{16'hFFFF, 1'b1, 16'h4321, 0, 0, 1'b1, 3'b000, -1};
        tbl[8]  = '{16'h6000, 1'b1, 16'hC0DE, 4, 4, 1'b0, 3'b100, 2};
        tbl[9]  = '{16'h3FFF, 1'b0, 16'h0000, 1, 1, 1'b0, 3'b000, 0};
        tbl[10] = '{16'h5FFF, 1'b1, 16'h9999, 5, 4, 1'b1, 3'b000, 1};

        // Reset asserted with a request pending: nothing may be issued.
        rst_n = 1'b0; req = 1'b1; load = 1'b1; address = 16'h0005; in = 16'h1234;
        req_b = 1'b0; tgt_busy = 3'b000; tgt_dout = {16'h3333, 16'hAAAA, 16'h5555};
        @(negedge clk); @(negedge clk);
        #2;
        chk("rst ready", ready, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst tgt_load", tgt_load, 3'b000);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out", out, c_def);
        @(negedge clk);
        rst_n = 1'b1;

        // First request after release is accepted at once; then the table.
        for (int i = 0; i < 11; i++) run_txn(tbl[i]);
        idle_cycle();
        idle_cycle();

        // Reset in the middle of a WAIT stall.
        req = 1'b1; load = 1'b0; address = 16'h4000; tgt_busy = 3'b010;
        #2; step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0);
        #2; step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0);
        #2; rst_n = 1'b0; #1;
        chk("wrst ready", ready, 1'b0);
        chk("wrst err", err, 1'b0);
        chk("wrst tgt_load", tgt_load, 3'b000);
        chk("wrst out_valid", out_valid, 1'b0);
        chk("wrst out", out, c_def);
        last_out = c_def; pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        req = 1'b1; load = 1'b1; address = 16'h0100; in = 16'h7777; tgt_busy = 3'b000;
        #2; chk("post-rst tgt_din", tgt_din, 16'h7777);
        step(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 0);
        idle_cycle();

        // Custom map: unmapped read, then overlapped address resolves to region 0.
        req = 1'b0;
        req_b = 1'b1; load = 1'b0; address = 16'h8000;
        #2;
        chk("b ready", ready_b, 1'b1);
        chk("b err", err_b, 1'b1);
        chk("b tgt_load", tgt_load_b, 2'b00);
        @(negedge clk);
        load = 1'b1; address = 16'h2100; in = 16'h5A5A;
        #2;
        chk("b out_valid", out_valid_b, 1'b1);
        chk("b out", out_b, c_defb);
        chk("b ready2", ready_b, 1'b1);
        chk("b err2", err_b, 1'b0);
        chk("b tgt_load2", tgt_load_b, 2'b01);
        @(negedge clk);
        req_b = 1'b0;
        #2;
        chk("b hold valid", out_valid_b, 1'b0);
        chk("b hold out", out_b, c_defb);
        @(negedge clk);

        // Randomized transactions against the reference model.
        rnd_dout = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom);
                1:       a = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
                2:       a = 16'h6000;
                default: a = 16'($urandom_range(0, 16'h3FFF));
            endcase
            run_txn(model_txn(a, 1'($urandom), 16'($urandom), $urandom_range(0, 6)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
